// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM stage and the memory: a multi-cycle req/ack handshake.
// The ack is a one-cycle pulse, and rdata is valid in the same cycle as the ack.
interface mem_access_unit_if;
    logic        dram_req;
    logic        dram_we;
    logic [31:0] dram_addr;
    logic [31:0] dram_wdata;
    logic        dram_ack;
    logic [31:0] dram_rdata;

    modport master (
        output dram_req, dram_we, dram_addr, dram_wdata,
        input  dram_ack, dram_rdata
    );

    modport slave (
        input  dram_req, dram_we, dram_addr, dram_wdata,
        output dram_ack, dram_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: runs loads/stores over a req/ack bus, stalls the pipeline while an
// access is outstanding, and registers the MEM/WB payload.
module mem_access_unit #(
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          MEM_rf_wsel,
    input  logic                MEM_rf_we,
    input  logic                MEM_dram_we,
    input  logic [31:0]         MEM_alu_c,
    input  logic [31:0]         MEM_rD2,
    input  logic [31:0]         MEM_pc4,
    input  logic [31:0]         MEM_ext,
    input  logic [31:0]         MEM_wR,
    mem_access_unit_if.master   mem_bus,
    output logic                mem_stall,
    output logic                bus_err,
    output logic                WB_rf_we,
    output logic [31:0]         WB_wR,
    output logic [31:0]         WB_wd
);
    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d;
    logic        we_q, we_d, err_q, err_d;
    logic        wb_we_q, wb_we_d;
    logic [31:0] wb_wr_q, wb_wr_d, wb_wd_q, wb_wd_d;

    logic load, store, access;

    assign load   = MEM_rf_we & (MEM_rf_wsel == 2'b01) & ~MEM_dram_we;
    assign store  = MEM_dram_we;
    assign access = load | store;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        ld_d    = ld_q;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (access) begin
                    if (MEM_alu_c[1:0] == 2'b00) begin
                        state_d = StReq;
                        addr_d  = MEM_alu_c;
                        wdata_d = MEM_rD2;
                        we_d    = store;
                        cnt_d   = 8'd0;
                    end else begin
                        // Misaligned: no bus cycle, a load returns zero.
                        state_d = StDone;
                        ld_d    = 32'd0;
                        err_d   = 1'b1;
                    end
                end
            end
            StReq: begin
                if (mem_bus.dram_ack) begin
                    state_d = StDone;
                    ld_d    = mem_bus.dram_rdata;
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StDone;
                    ld_d    = ERR_RDATA;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // DONE releases the stall so the EX/MEM register advances exactly once per access.
    assign mem_stall = access & (state_q != StDone);

    always_comb begin
        wb_we_d = 1'b0;
        wb_wr_d = wb_wr_q;
        wb_wd_d = wb_wd_q;
        if (!mem_stall) begin
            wb_we_d = MEM_rf_we & ~store;
            wb_wr_d = MEM_wR;
            case (MEM_rf_wsel)
                2'b00:   wb_wd_d = MEM_alu_c;
                2'b01:   wb_wd_d = ld_q;
                2'b10:   wb_wd_d = MEM_pc4;
                default: wb_wd_d = MEM_ext;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            ld_q    <= 32'd0;
            err_q   <= 1'b0;
            wb_we_q <= 1'b0;
            wb_wr_q <= 32'd0;
            wb_wd_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
            wb_we_q <= wb_we_d;
            wb_wr_q <= wb_wr_d;
            wb_wd_q <= wb_wd_d;
        end
    end

    assign mem_bus.dram_req   = (state_q == StReq);
    assign mem_bus.dram_we    = we_q;
    assign mem_bus.dram_addr  = addr_q;
    assign mem_bus.dram_wdata = wdata_q;
    assign bus_err            = err_q;
    assign WB_rf_we           = wb_we_q;
    assign WB_wR              = wb_wr_q;
    assign WB_wd              = wb_wd_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed instructions, a bus responder with programmable ack delay,
// and a writeback scoreboard popped by an independent monitor.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  MEM_rf_wsel = 2'b00;
    logic        MEM_rf_we = 1'b0, MEM_dram_we = 1'b0;
    logic [31:0] MEM_alu_c = '0, MEM_rD2 = '0, MEM_pc4 = '0, MEM_ext = '0, MEM_wR = '0;
    logic        mem_stall, bus_err, WB_rf_we;
    logic [31:0] WB_wR, WB_wd;

    logic        resp_ack = 1'b0, stray_ack = 1'b0;
    logic [31:0] resp_rdata = '0;

    int          tests = 0, fails = 0;
    int          ack_at = 0;
    logic [31:0] ack_data = '0;
    logic [31:0] exp_addr = '0, exp_wdata = '0;
    logic        exp_we = 1'b0;
    int          stall_cnt, req_cnt, err_cnt;

    typedef struct {
        logic [31:0] wr;
        logic [31:0] wd;
    } wb_t;
    wb_t exp_q[$];

    always #5 clk = ~clk;

    mem_access_unit_if bus ();
    assign bus.dram_ack   = resp_ack | stray_ack;
    assign bus.dram_rdata = resp_rdata;

    mem_access_unit #(.TIMEOUT(4), .ERR_RDATA(32'hDEADBEEF)) dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_rf_wsel(MEM_rf_wsel),
        .MEM_rf_we  (MEM_rf_we),
        .MEM_dram_we(MEM_dram_we),
        .MEM_alu_c  (MEM_alu_c),
        .MEM_rD2    (MEM_rD2),
        .MEM_pc4    (MEM_pc4),
        .MEM_ext    (MEM_ext),
        .MEM_wR     (MEM_wR),
        .mem_bus    (bus.master),
        .mem_stall  (mem_stall),
        .bus_err    (bus_err),
        .WB_rf_we   (WB_rf_we),
        .WB_wR      (WB_wR),
        .WB_wd      (WB_wd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory model: acks on the ack_at-th request cycle of an access (0 = never).
    initial begin
        int rc;
        rc = 0;
        forever begin
            @(negedge clk);
            if (bus.dram_req) begin
                rc++;
                resp_ack   = (ack_at != 0) && (rc == ack_at);
                resp_rdata = resp_ack ? ack_data : 32'h0;
            end else begin
                rc         = 0;
                resp_ack   = 1'b0;
                resp_rdata = 32'h0;
            end
        end
    end

    // Monitor: bus fields must be stable while requesting; every writeback pops the scoreboard.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (bus.dram_req) begin
                check("bus_addr", bus.dram_addr, exp_addr);
                check("bus_we", 32'(bus.dram_we), 32'(exp_we));
                if (exp_we) check("bus_wdata", bus.dram_wdata, exp_wdata);
            end
            if (WB_rf_we) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL wb_unexpected: got wR=%h wd=%h, expected no writeback",
                             WB_wR, WB_wd);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_wR", WB_wR, e.wr);
                    check("wb_wd", WB_wd, e.wd);
                end
            end
        end
    end

    task automatic drive_nop();
        MEM_rf_we   = 1'b0;
        MEM_dram_we = 1'b0;
        MEM_rf_wsel = 2'b00;
    endtask

    task automatic issue(input string name, input logic [1:0] wsel, input logic rfwe,
                         input logic dwe, input logic [31:0] alu, input logic [31:0] rd2,
                         input logic [31:0] pc4, input logic [31:0] ext, input logic [31:0] wr,
                         input int ackat, input logic [31:0] rdata, input logic push,
                         input logic [31:0] expwd, input int estall, input int ereq,
                         input int eerr);
        int n;
        @(posedge clk);
        #1;
        MEM_rf_wsel = wsel; MEM_rf_we = rfwe; MEM_dram_we = dwe;
        MEM_alu_c = alu; MEM_rD2 = rd2; MEM_pc4 = pc4; MEM_ext = ext; MEM_wR = wr;
        exp_addr = alu; exp_we = dwe; exp_wdata = rd2;
        ack_at = ackat; ack_data = rdata;
        if (push) exp_q.push_back('{wr: wr, wd: expwd});
        stall_cnt = 0; req_cnt = 0; err_cnt = 0;
        n = 0;
        forever begin
            @(negedge clk);
            if (mem_stall) stall_cnt++;
            if (bus.dram_req) req_cnt++;
            if (bus_err) err_cnt++;
            n++;
            if (!mem_stall || n > 50) break;
        end
        if (n > 50) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got stall after %0d cycles, expected release", name, n);
        end
        @(posedge clk);
        #1;
        drive_nop();
        check({name, "_stall"}, 32'(stall_cnt), 32'(estall));
        check({name, "_req"}, 32'(req_cnt), 32'(ereq));
        check({name, "_err"}, 32'(err_cnt), 32'(eerr));
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        #12;
        check("rst_req", 32'(bus.dram_req), 32'd0);
        check("rst_addr", bus.dram_addr, 32'd0);
        check("rst_wdata", bus.dram_wdata, 32'd0);
        check("rst_we", 32'(bus.dram_we), 32'd0);
        check("rst_err", 32'(bus_err), 32'd0);
        check("rst_wbwe", 32'(WB_rf_we), 32'd0);
        check("rst_wbwr", WB_wR, 32'd0);
        check("rst_wbwd", WB_wd, 32'd0);
        check("rst_stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        //     name     wsel   rfwe dwe alu            rd2            pc4       ext
        //     wR     ackat rdata         push wd             stall req err
        issue("alu",    2'b00, 1, 0, 32'h1234,      32'h0,         32'h0,    32'h0,
              32'd5,  0, 32'h0,         1, 32'h1234,       0, 0, 0);
        issue("load",   2'b01, 1, 0, 32'h40,        32'h0,         32'h0,    32'h0,
              32'd7,  1, 32'hCAFEF00D,  1, 32'hCAFEF00D,   2, 1, 0);
        issue("store",  2'b00, 0, 1, 32'h80,        32'h55AA55AA,  32'h0,    32'h0,
              32'd3,  3, 32'h0,         0, 32'h0,          4, 3, 0);
        issue("tmo",    2'b01, 1, 0, 32'h100,       32'h0,         32'h0,    32'h0,
              32'd9,  0, 32'h0,         1, 32'hDEADBEEF,   5, 4, 1);
        issue("misal",  2'b01, 1, 0, 32'h42,        32'h0,         32'h0,    32'h0,
              32'd10, 0, 32'h0,         1, 32'h0,          1, 0, 1);
        issue("pc4",    2'b10, 1, 0, 32'h77,        32'h0,         32'h2004, 32'h0,
              32'd1,  0, 32'h0,         1, 32'h2004,       0, 0, 0);
        issue("ext",    2'b11, 1, 0, 32'h78,        32'h0,         32'h0,    32'hFFFFF800,
              32'd31, 0, 32'h0,         1, 32'hFFFFF800,   0, 0, 0);
        issue("st_wb",  2'b01, 1, 1, 32'hC,         32'h13579BDF,  32'h0,    32'h0,
              32'd12, 1, 32'h0,         0, 32'h0,          2, 1, 0);
        issue("load2",  2'b01, 1, 0, 32'h1F0,       32'h0,         32'h0,    32'h0,
              32'd20, 2, 32'h12345678,  1, 32'h12345678,   3, 2, 0);
        issue("st_mis", 2'b00, 0, 1, 32'h81,        32'h0,         32'h0,    32'h0,
              32'd2,  0, 32'h0,         0, 32'h0,          1, 0, 1);

        // Reset in the middle of a request, then a stray ack after release.
        @(posedge clk);
        #1;
        MEM_rf_wsel = 2'b01; MEM_rf_we = 1'b1; MEM_dram_we = 1'b0;
        MEM_alu_c = 32'h200; MEM_wR = 32'd4;
        exp_addr = 32'h200; exp_we = 1'b0; ack_at = 0;
        @(negedge clk);
        @(negedge clk);
        check("mid_req", 32'(bus.dram_req), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_req", 32'(bus.dram_req), 32'd0);
        check("arst_addr", bus.dram_addr, 32'd0);
        check("arst_wbwe", 32'(WB_rf_we), 32'd0);
        check("arst_wbwd", WB_wd, 32'd0);
        check("arst_err", 32'(bus_err), 32'd0);
        drive_nop();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        stray_ack = 1'b1;
        @(posedge clk);
        #1;
        stray_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_req", 32'(bus.dram_req), 32'd0);
            check("stray_wbwe", 32'(WB_rf_we), 32'd0);
        end

        repeat (2) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
